// File: rtl/stopwatch_pkg.sv
// Shared types and field limits for the stopwatch timebase.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } sw_state_e;

  localparam logic [7:0] CS_MAX  = 8'd99;
  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] HR_MAX  = 8'd99;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF synchroniser -> stable counter -> one-cycle press pulse.
// Press pulse appears DBC+3 clocks after the raw key falls; release yields nothing.
module key_debounce #(
  parameter int unsigned DBC = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DBC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DBC - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_prev_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  // Synchronise, require DBC consecutive differing samples to flip, detect falling level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      level_prev_q <= level_q;
      press_q      <= level_prev_q & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_core.sv
// hh:mm:ss'cc stopwatch timebase with start/stop, lap and clear keys.
// Define STOPWATCH_LAP_PAUSE_EN to also accept lap while paused (strobes the frozen time).
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iKEY_StartStop,
  input  logic       iKEY_Lap,
  input  logic       iKEY_Clear,
  output logic [7:0] oHour,
  output logic [7:0] oMinute,
  output logic [7:0] oSecond,
  output logic [7:0] oCS,
  output logic       oRecord_N,
  output logic       oRunning
);

  localparam int unsigned DBC       = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned PRESC_DIV = CLK_HZ / 100;
  localparam int unsigned PrescW    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESC_DIV - 1);

  logic ss_p, lap_p, clr_p;
  logic lap_ok, tick;

  sw_state_e         state_q;
  logic [PrescW-1:0] presc_q;
  logic [7:0]        hour_q, min_q, sec_q, cs_q;
  logic              record_nq;

  key_debounce #(.DBC(DBC)) u_key_ss (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .key_ni (iKEY_StartStop),
    .press_o(ss_p)
  );

  key_debounce #(.DBC(DBC)) u_key_lap (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .key_ni (iKEY_Lap),
    .press_o(lap_p)
  );

  key_debounce #(.DBC(DBC)) u_key_clr (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .key_ni (iKEY_Clear),
    .press_o(clr_p)
  );

  // Lap acceptance uses the pre-transition state; tick fires only while running.
  always_comb begin
`ifdef STOPWATCH_LAP_PAUSE_EN
    lap_ok = lap_p & ((state_q == StRun) | (state_q == StPause));
`else
    lap_ok = lap_p & (state_q == StRun);
`endif
    tick = (state_q == StRun) && (presc_q == PrescLast);
  end

  // Control FSM, prescaler, time-field cascade and lap strobe.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      cs_q      <= '0;
      record_nq <= 1'b1;
    end else begin
      record_nq <= ~lap_ok;

      if (state_q == StRun) begin
        if (tick) begin
          presc_q <= '0;
          if (cs_q == CS_MAX) begin
            cs_q <= '0;
            if (sec_q == SEC_MAX) begin
              sec_q <= '0;
              if (min_q == MIN_MAX) begin
                min_q  <= '0;
                hour_q <= (hour_q == HR_MAX) ? 8'd0 : hour_q + 8'd1;
              end else begin
                min_q <= min_q + 8'd1;
              end
            end else begin
              sec_q <= sec_q + 8'd1;
            end
          end else begin
            cs_q <= cs_q + 8'd1;
          end
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end

      // startstop outranks clear; clear is ignored while running.
      unique case (state_q)
        StIdle: begin
          if (ss_p) state_q <= StRun;
        end
        StRun: begin
          if (ss_p) state_q <= StPause;
        end
        StPause: begin
          if (ss_p) begin
            state_q <= StRun;
          end else if (clr_p) begin
            state_q <= StIdle;
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            cs_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oHour     = hour_q;
  assign oMinute   = min_q;
  assign oSecond   = sec_q;
  assign oCS       = cs_q;
  assign oRecord_N = record_nq;
  assign oRunning  = (state_q == StRun);

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at CLK_HZ=1000 (tick every 10 clocks), DBC=20.
// Edge En below means n clock edges after the point where a key was first driven.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_ss, key_lap, key_clr;
  logic [7:0] hour, minute, second, cs;
  logic       record_n, running;

  int total = 0;
  int bad   = 0;

  stopwatch_core #(
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(20)
  ) dut (
    .iCLK          (clk),
    .iRST          (rst),
    .iKEY_StartStop(key_ss),
    .iKEY_Lap      (key_lap),
    .iKEY_Clear    (key_clr),
    .oHour         (hour),
    .oMinute       (minute),
    .oSecond       (second),
    .oCS           (cs),
    .oRecord_N     (record_n),
    .oRunning      (running)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int c);
    chk({tag, ".hour"}, 32'(hour), 32'(h));
    chk({tag, ".min"},  32'(minute), 32'(m));
    chk({tag, ".sec"},  32'(second), 32'(s));
    chk({tag, ".cs"},   32'(cs), 32'(c));
  endtask

  int pulses;
  int run_edges;
  logic run_prev;

  initial begin
    key_ss  = 1'b1;
    key_lap = 1'b1;
    key_clr = 1'b1;
    rst     = 1'b1;
    tick(2);
    chk_time("reset", 0, 0, 0, 0);
    chk("reset.record_n", 32'(record_n), 32'd1);
    chk("reset.running", 32'(running), 32'd0);
    rst = 1'b0;

    // 1: start press, pulse latency DBC+3, first second after 1000 clocks in RUN
    key_ss = 1'b0;
    tick(22);
    chk("t1.no_pulse_e22", 32'(dut.u_key_ss.press_o), 32'd0);
    tick(1);
    chk("t1.pulse_e23", 32'(dut.u_key_ss.press_o), 32'd1);
    chk("t1.idle_e23", 32'(running), 32'd0);
    tick(1);
    chk("t1.running_e24", 32'(running), 32'd1);
    chk("t1.pulse_gone_e24", 32'(dut.u_key_ss.press_o), 32'd0);
    tick(7);
    key_ss = 1'b1;
    tick(992);
    chk_time("t1.e1023", 0, 0, 0, 99);
    tick(1);
    chk_time("t1.e1024", 0, 0, 1, 0);

    // 2: chatter on startstop collapses to one press
    do_reset();
    pulses    = 0;
    run_edges = 0;
    run_prev  = running;
    for (int i = 0; i < 10; i++) begin
      key_ss = (i % 2 == 1);
      for (int j = 0; j < 5; j++) begin
        tick(1);
        if (dut.u_key_ss.press_o === 1'b1) pulses++;
        if (running !== run_prev) run_edges++;
        run_prev = running;
      end
    end
    key_ss = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tick(1);
      if (dut.u_key_ss.press_o === 1'b1) pulses++;
      if (running !== run_prev) run_edges++;
      run_prev = running;
    end
    chk("t2.pulses", 32'(pulses), 32'd1);
    chk("t2.state_changes", 32'(run_edges), 32'd1);
    chk("t2.running", 32'(running), 32'd1);
    key_ss = 1'b1;

    // 3: lap at 00:00:05'42 strobes one clock with that time
    do_reset();
    key_ss = 1'b0;
    tick(31);
    key_ss = 1'b1;
    tick(5392);
    key_lap = 1'b0;
    tick(23);
    chk("t3.record_before", 32'(record_n), 32'd1);
    tick(1);
    chk("t3.record_low", 32'(record_n), 32'd0);
    chk_time("t3.snap", 0, 0, 5, 42);
    tick(1);
    chk("t3.record_after", 32'(record_n), 32'd1);
    tick(5);
    key_lap = 1'b1;

    // 5: pause at 03'17, hold, clear to idle, clear ignored in RUN
    do_reset();
    key_ss = 1'b0;
    tick(31);
    key_ss = 1'b1;
    tick(3176 - 31);
    key_ss = 1'b0;
    tick(24);
    chk("t5.paused", 32'(running), 32'd0);
    chk_time("t5.pause", 0, 0, 3, 17);
    tick(6);
    key_ss = 1'b1;
    tick(494);
    chk_time("t5.held", 0, 0, 3, 17);
    key_clr = 1'b0;
    tick(23);
    chk_time("t5.before_clear", 0, 0, 3, 17);
    tick(1);
    chk_time("t5.cleared", 0, 0, 0, 0);
    chk("t5.idle", 32'(running), 32'd0);
    tick(6);
    key_clr = 1'b1;
    tick(10);
    key_ss = 1'b0;
    tick(24);
    chk("t5.restart", 32'(running), 32'd1);
    tick(6);
    key_ss = 1'b1;
    tick(30);
    key_clr = 1'b0;
    tick(30);
    chk("t5.run_clear.running", 32'(running), 32'd1);
    chk_time("t5.run_clear", 0, 0, 0, 6);
    tick(1);
    key_clr = 1'b1;

    // 4: rollover 99:59:59'99 -> 00:00:00'00 while running
    do_reset();
    key_ss = 1'b0;
    tick(30);
    force dut.hour_q = 8'd99;
    force dut.min_q  = 8'd59;
    force dut.sec_q  = 8'd59;
    force dut.cs_q   = 8'd99;
    #1;
    release dut.hour_q;
    release dut.min_q;
    release dut.sec_q;
    release dut.cs_q;
    @(posedge clk);
    #1;
    tick(2);
    chk_time("t4.max", 99, 59, 59, 99);
    tick(1);
    chk_time("t4.wrap", 0, 0, 0, 0);
    chk("t4.running", 32'(running), 32'd1);
    key_ss = 1'b1;

    // 6: lap in IDLE with simultaneous start, lap in PAUSE, ss+clear, reset mid-strobe
    do_reset();
    key_ss  = 1'b0;
    key_lap = 1'b0;
    tick(24);
    chk("t6.start_running", 32'(running), 32'd1);
    chk("t6.idle_lap_ignored", 32'(record_n), 32'd1);
    tick(7);
    key_ss  = 1'b1;
    key_lap = 1'b1;
    tick(29);
    key_ss = 1'b0;
    tick(24);
    chk("t6.paused", 32'(running), 32'd0);
    chk("t6.pause_cs", 32'(cs), 32'd6);
    tick(7);
    key_ss = 1'b1;
    tick(9);
    key_lap = 1'b0;
    tick(23);
    chk("t6.pause_lap_pre", 32'(record_n), 32'd1);
    tick(1);
`ifdef STOPWATCH_LAP_PAUSE_EN
    chk("t6.pause_lap_strobe", 32'(record_n), 32'd0);
    chk("t6.pause_lap_cs", 32'(cs), 32'd6);
`else
    chk("t6.pause_lap_ignored", 32'(record_n), 32'd1);
`endif
    tick(1);
    chk("t6.pause_lap_post", 32'(record_n), 32'd1);
    tick(6);
    key_lap = 1'b1;
    tick(29);
    key_ss  = 1'b0;
    key_clr = 1'b0;
    tick(24);
    chk("t6.resume_not_clear", 32'(running), 32'd1);
    chk("t6.resume_cs", 32'(cs), 32'd6);
    tick(7);
    key_ss  = 1'b1;
    key_clr = 1'b1;
    tick(3);
    chk("t6.phase_kept", 32'(cs), 32'd7);
    tick(26);
    key_lap = 1'b0;
    tick(24);
    chk("t6.run_strobe", 32'(record_n), 32'd0);
    rst = 1'b1;
    tick(1);
    chk("t6.rst_record", 32'(record_n), 32'd1);
    chk("t6.rst_running", 32'(running), 32'd0);
    chk("t6.rst_cs", 32'(cs), 32'd0);
    rst     = 1'b0;
    key_lap = 1'b1;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
